// File: rtl/ifm_bank_rsp.sv
// ifm_bank_rsp: memory-side responder for one IFM SRAM bank on the conv
// read-DMA address/data interface.
//
// Each accepted {addr, first, last} request issues one synchronous SRAM read.
// The returned word and its tags go into an output FIFO and come back in
// request order. Requests are accepted only while there is room in the FIFO
// for every read already in flight, so the FIFO cannot overflow.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_addr*           request channel (valid/ready)
//   mem_ren/raddr     SRAM read port; mem_rdata is valid the cycle after mem_ren
//   m_data/first/last returned beat with its request tags (valid/ready)
//   busy              burst open, read in flight, or FIFO non-empty
//   proto_err         sticky first/last sequencing error, cleared only by rst
//
// Optional feature (macro IFM_BANK_RSP_PAD_EN): the all-ones address is a
// padding request. It uses a credit like any other request but does not read
// the SRAM, and it returns a zero word.
module ifm_bank_rsp #(
  parameter int unsigned DW = 8,
  parameter int unsigned DN = 7,
  parameter int unsigned AW = 14,
  parameter int unsigned FD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    s_addr,
  input  logic             s_addr_first,
  input  logic             s_addr_last,
  input  logic             s_addr_valid,
  output logic             s_addr_ready,
  output logic             mem_ren,
  output logic [AW-1:0]    mem_raddr,
  input  logic [DN*DW-1:0] mem_rdata,
  output logic [DN*DW-1:0] m_data,
  output logic             m_first,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             proto_err
);

  localparam int unsigned DWD = DN * DW;
  localparam int unsigned PW  = $clog2(FD);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t state, state_nxt;

  logic [DWD-1:0] fifo_data  [FD];
  logic           fifo_first [FD];
  logic           fifo_last  [FD];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;

  logic           infl_v, infl_first, infl_last, infl_pad;

  logic [CW-1:0]  occ;
  logic           accept, is_pad, push, pop, err_set;
  logic [DWD-1:0] push_data;

  // Credits come only from registered state, so a pop this cycle frees its
  // slot for requests only from the next cycle on.
  assign occ          = count + CW'(infl_v);
  assign s_addr_ready = (occ < CW'(FD)) && !rst;
  assign accept       = s_addr_valid && s_addr_ready;

`ifdef IFM_BANK_RSP_PAD_EN
  assign is_pad = (s_addr == '1);
`else
  assign is_pad = 1'b0;
`endif

  assign mem_ren   = accept && !is_pad;
  assign mem_raddr = s_addr;

  assign push      = infl_v;
  assign pop       = m_valid && m_ready;
  assign push_data = infl_pad ? '0 : mem_rdata;

  // Outputs are driven straight from FIFO storage and forced to zero while
  // empty, which gives the all-zero reset values without resetting storage.
  assign m_valid = (count != '0);
  assign m_data  = m_valid ? fifo_data[rd_ptr]  : '0;
  assign m_first = m_valid ? fifo_first[rd_ptr] : 1'b0;
  assign m_last  = m_valid ? fifo_last[rd_ptr]  : 1'b0;

  assign busy = (state == BURST) || infl_v || m_valid;

  // In-flight read register: tags wait here for the SRAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_v     <= 1'b0;
      infl_first <= 1'b0;
      infl_last  <= 1'b0;
      infl_pad   <= 1'b0;
    end else begin
      infl_v     <= accept;
      infl_first <= s_addr_first;
      infl_last  <= s_addr_last;
      infl_pad   <= is_pad;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr]  <= push_data;
      fifo_first[wr_ptr] <= infl_first;
      fifo_last[wr_ptr]  <= infl_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Whatever the current state, an accepted request closes the burst when it
  // carries last and leaves one open otherwise; only the error check depends
  // on the state.
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    if (accept) begin
      state_nxt = s_addr_last ? IDLE : BURST;
      err_set   = (state == BURST) ? s_addr_first : !s_addr_first;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_set) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifm_bank_rsp.sv
module tb_ifm_bank_rsp;

  localparam int unsigned DW = 8;
  localparam int unsigned DN = 7;
  localparam int unsigned AW = 14;
  localparam int unsigned FD = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [AW-1:0]  s_addr = '0;
  logic           s_addr_first = 1'b0;
  logic           s_addr_last = 1'b0;
  logic           s_addr_valid = 1'b0;
  logic           s_addr_ready;
  logic           mem_ren;
  logic [AW-1:0]  mem_raddr;
  logic [55:0]    mem_rdata = '0;
  logic [55:0]    m_data;
  logic           m_first, m_last, m_valid;
  logic           m_ready = 1'b0;
  logic           busy, proto_err;

  int unsigned total = 0;
  int unsigned bad = 0;

  ifm_bank_rsp #(.DW(DW), .DN(DN), .AW(AW), .FD(FD)) dut (
    .clk(clk), .rst(rst),
    .s_addr(s_addr), .s_addr_first(s_addr_first), .s_addr_last(s_addr_last),
    .s_addr_valid(s_addr_valid), .s_addr_ready(s_addr_ready),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .m_data(m_data), .m_first(m_first), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // SRAM model: word at address a holds a*3, one cycle read latency.
  always @(posedge clk) if (mem_ren) mem_rdata <= 56'(mem_raddr) * 56'd3;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_addr_valid = 1'b1;
    s_addr = 14'h005;
    #1;
    total++;
    if (s_addr_ready !== 1'b0 || mem_ren !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 ||
        proto_err !== 1'b0 || m_data !== 56'd0 || m_first !== 1'b0 || m_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: ready=%b ren=%b valid=%b busy=%b err=%b data=%h f=%b l=%b required all 0",
               s_addr_ready, mem_ren, m_valid, busy, proto_err, m_data, m_first, m_last);
    end
    s_addr_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
    total++;
    if (s_addr_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: ready=%b busy=%b required ready=1 busy=0", s_addr_ready, busy);
    end
  endtask

  task automatic test_single_burst();
    int unsigned nb = 0;
    int unsigned first_cyc = 99;
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      s_addr_valid = (c < 4);
      s_addr       = 14'h010 + 14'(c);
      s_addr_first = (c == 0);
      s_addr_last  = (c == 3);
      #1;
      if (c < 4) begin
        total++;
        if (s_addr_ready !== 1'b1 || mem_ren !== 1'b1 || mem_raddr !== 14'h010 + 14'(c)) begin
          bad++;
          $display("FAIL burst_req%0d: ready=%b ren=%b raddr=%h required 1 1 %h",
                   c, s_addr_ready, mem_ren, mem_raddr, 14'h010 + 14'(c));
        end
      end
      if (m_valid === 1'b1) begin
        if (nb == 0) first_cyc = c;
        total++;
        if (nb >= 4 || m_data !== 56'h030 + 56'(3 * nb) || m_first !== (nb == 0) || m_last !== (nb == 3)) begin
          bad++;
          $display("FAIL burst_beat%0d: data=%h f=%b l=%b required %h %b %b",
                   nb, m_data, m_first, m_last, 56'h030 + 56'(3 * nb), nb == 0, nb == 3);
        end
        nb++;
      end
    end
    s_addr_valid = 1'b0;
    total++;
    if (nb != 4 || first_cyc != 2) begin
      bad++;
      $display("FAIL burst_count: beats=%0d first_cycle=%0d required 4 and 2", nb, first_cyc);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL burst_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int unsigned acc = 0;
    int unsigned nb = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      s_addr_valid = (acc < 6);
      s_addr       = 14'h020 + 14'(acc);
      s_addr_first = (acc == 0);
      s_addr_last  = (acc == 5);
      #1;
      if (s_addr_valid && s_addr_ready) acc++;
    end
    total++;
    if (acc != FD || s_addr_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accepted: accepted=%0d ready=%b required %0d and 0", acc, s_addr_ready, FD);
    end
    total++;
    if (m_valid !== 1'b1 || m_data !== 56'h060 || m_first !== 1'b1) begin
      bad++;
      $display("FAIL bp_stall_head: valid=%b data=%h first=%b required 1 000060 1", m_valid, m_data, m_first);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (m_valid === 1'b1) begin
        total++;
        if (nb >= 6 || m_data !== 56'(14'h020 + 14'(nb)) * 56'd3 ||
            m_first !== (nb == 0) || m_last !== (nb == 5)) begin
          bad++;
          $display("FAIL bp_beat%0d: data=%h f=%b l=%b required %h %b %b",
                   nb, m_data, m_first, m_last, 56'(14'h020 + 14'(nb)) * 56'd3, nb == 0, nb == 5);
        end
        nb++;
      end
      next_cycle();
      s_addr_valid = (acc < 6);
      s_addr       = 14'h020 + 14'(acc);
      s_addr_first = (acc == 0);
      s_addr_last  = (acc == 5);
      #1;
      if (s_addr_valid && s_addr_ready) acc++;
    end
    s_addr_valid = 1'b0;
    total++;
    if (nb != 6 || acc != 6 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: beats=%0d accepted=%0d busy=%b required 6 6 0", nb, acc, busy);
    end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      s_addr_valid = (c < 8);
      s_addr       = 14'h100 + 14'(c);
      s_addr_first = (c == 0);
      s_addr_last  = (c == 7);
      #1;
      if (c < 8) begin
        total++;
        if (s_addr_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready%0d: ready=%b required 1", c, s_addr_ready);
        end
      end
      if (c >= 2 && c <= 9) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== 56'h300 + 56'(3 * (c - 2))) begin
          bad++;
          $display("FAIL b2b_beat%0d: valid=%b data=%h required 1 %h",
                   c - 2, m_valid, m_data, 56'h300 + 56'(3 * (c - 2)));
        end
      end else begin
        total++;
        if (m_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_gap%0d: valid=%b required 0", c, m_valid);
        end
      end
    end
    s_addr_valid = 1'b0;
  endtask

  task automatic test_proto_err();
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      s_addr_valid = (c < 2);
      s_addr       = 14'h040 + 14'(c);
      s_addr_first = 1'b1;
      s_addr_last  = 1'b0;
      #1;
      if (c == 1) begin
        total++;
        if (proto_err !== 1'b0) begin
          bad++;
          $display("FAIL perr_early: proto_err=%b required 0", proto_err);
        end
      end
      if (c >= 2) begin
        total++;
        if (proto_err !== 1'b1) begin
          bad++;
          $display("FAIL perr_sticky%0d: proto_err=%b required 1", c, proto_err);
        end
      end
      if (c == 2 || c == 3) begin
        total++;
        if (m_valid !== 1'b1 || m_first !== 1'b1 || m_data !== 56'h0C0 + 56'(3 * (c - 2))) begin
          bad++;
          $display("FAIL perr_beat%0d: valid=%b first=%b data=%h required 1 1 %h",
                   c - 2, m_valid, m_first, m_data, 56'h0C0 + 56'(3 * (c - 2)));
        end
      end
    end
    s_addr_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (proto_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL perr_clear: proto_err=%b busy=%b required 0 0", proto_err, busy);
    end
    // Continuation beat with no open burst is also an error.
    next_cycle();
    s_addr_valid = 1'b1;
    s_addr       = 14'h050;
    s_addr_first = 1'b0;
    s_addr_last  = 1'b1;
    next_cycle();
    s_addr_valid = 1'b0;
    #1;
    total++;
    if (proto_err !== 1'b1) begin
      bad++;
      $display("FAIL perr_nofirst: proto_err=%b required 1", proto_err);
    end
    next_cycle();
    next_cycle();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL perr_nofirst_idle: busy=%b required 0", busy);
    end
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      s_addr_valid = (c < 3);
      s_addr       = 14'h060 + 14'(c);
      s_addr_first = (c == 0);
      s_addr_last  = 1'b0;
      #1;
    end
    s_addr_valid = 1'b0;
    total++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rmid_queued: valid=%b busy=%b required 1 1", m_valid, busy);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (m_valid !== 1'b0 || s_addr_ready !== 1'b0 || m_data !== 56'd0) begin
      bad++;
      $display("FAIL rmid_async: valid=%b ready=%b data=%h required 0 0 0", m_valid, s_addr_ready, m_data);
    end
    next_cycle();
    rst = 1'b0;
    m_ready = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || s_addr_ready !== 1'b1 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_release: busy=%b ready=%b valid=%b required 0 1 0", busy, s_addr_ready, m_valid);
    end
    next_cycle();
    next_cycle();
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_empty: valid=%b busy=%b required 0 0", m_valid, busy);
    end
  endtask

  task automatic test_pad();
    logic        exp_ren;
    logic [55:0] exp_data;
`ifdef IFM_BANK_RSP_PAD_EN
    exp_ren  = 1'b0;
    exp_data = 56'd0;
`else
    exp_ren  = 1'b1;
    exp_data = 56'h00BFFD;
`endif
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      s_addr_valid = (c == 0);
      s_addr       = 14'h3FFF;
      s_addr_first = 1'b1;
      s_addr_last  = 1'b1;
      #1;
      if (c == 0) begin
        total++;
        if (s_addr_ready !== 1'b1 || mem_ren !== exp_ren) begin
          bad++;
          $display("FAIL pad_ren: ready=%b ren=%b required 1 %b", s_addr_ready, mem_ren, exp_ren);
        end
      end
      if (c == 2) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== exp_data || m_first !== 1'b1 || m_last !== 1'b1) begin
          bad++;
          $display("FAIL pad_beat: valid=%b data=%h f=%b l=%b required 1 %h 1 1",
                   m_valid, m_data, m_first, m_last, exp_data);
        end
      end
    end
    s_addr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_backpressure();
    test_back_to_back();
    test_proto_err();
    test_reset_mid();
    test_pad();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/ifm_bank_rsp.md
Name: ifm_bank_rsp

Overview:
- Memory-side responder for one IFM SRAM bank on the conv read-DMA address/data interface.
- Accepts {addr, first, last} requests with valid/ready and issues a synchronous SRAM read per request.
- Returns each read word as a DN*DW-bit beat with first/last tags, in request order, through a credit-protected output FIFO.
- One instance per bank; three instances serve banks 0/1/2 of the conv read path.

Parameters:
- DW, 8, bits per pixel element.
- DN, 7, elements per returned word; data width is DN*DW = 56.
- AW, 14, SRAM word address width.
- FD, 4, output FIFO depth in beats (power of two, >= 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_addr  in  AW  request word address
- s_addr_first  in  1  first request of a burst
- s_addr_last  in  1  last request of a burst
- s_addr_valid  in  1  request valid
- s_addr_ready  out  1  request accepted when valid&ready
- mem_ren  out  1  SRAM read enable
- mem_raddr  out  AW  SRAM read address
- mem_rdata  in  DN*DW  SRAM read data, valid the cycle after mem_ren
- m_data  out  DN*DW  returned word
- m_first  out  1  tag copied from the request's s_addr_first
- m_last  out  1  tag copied from the request's s_addr_last
- m_valid  out  1  beat valid
- m_ready  in  1  beat consumed when valid&ready
- busy  out  1  burst open, read in flight, or FIFO non-empty
- proto_err  out  1  sticky protocol error flag

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: s_addr_ready=0 while rst is asserted, 1 from the first cycle after release. mem_ren=0, m_valid=0, m_first=0, m_last=0, m_data=0, busy=0, proto_err=0. FIFO empty, in-flight flag clear, FSM in IDLE.
- Handshake: a request is accepted when s_addr_valid&s_addr_ready. Requesters must hold s_addr, s_addr_first and s_addr_last stable while valid is high and not ready. An output beat is popped when m_valid&m_ready.
- SRAM interface: mem_ren = s_addr_valid&s_addr_ready, driven combinationally. mem_raddr = s_addr.
- Read pipeline: a one-entry in-flight register holds {first, last} and a valid bit. mem_rdata is captured into the FIFO together with its tags in the cycle after acceptance.
- Latency: a request accepted in cycle t has m_valid=1 in cycle t+2 at the earliest. Data leaves from registered FIFO outputs.
- Credits: occ = FIFO count + in-flight valid bit. s_addr_ready = (occ < FD) && !rst.
  - A pop in the same cycle does not add a credit that cycle; this keeps the ready path registered-only.
  - The FIFO therefore never overflows. A full FIFO with m_ready=0 stalls requests indefinitely without losing data.
- FIFO corner cases:
  - Simultaneous push and pop: count unchanged.
  - Pop while empty: impossible, since m_valid=0.
  - Pointers are log2(FD) bits and wrap modulo FD.
- Burst FSM, which tracks accepted requests only:
  - IDLE --accepted first&!last--> BURST.
  - IDLE --accepted first&last--> IDLE (single-beat burst).
  - BURST --accepted last--> IDLE.
  - BURST --accepted first--> proto_err=1; the request is still served and the new burst starts (stays BURST, or goes to IDLE if last is also set).
  - IDLE --accepted !first--> proto_err=1; the request is still served and the FSM moves to BURST (or stays IDLE if last is set).
- proto_err: cleared only by rst.
- busy: (state==BURST) | in-flight valid | FIFO non-empty.
- Reset mid-operation: the FIFO and in-flight read are discarded and outputs return to reset values immediately. A dropped in-flight mem_rdata is ignored.

Optional Feature:
- Macro IFM_BANK_RSP_PAD_EN.
- When defined, the all-ones address ({AW{1'b1}}) is a padding request:
  - It is accepted under the normal credit rule.
  - mem_ren stays 0 for it.
  - Zero data is pushed into the FIFO with the normal tags and the same t+2 latency.
- When not defined, the all-ones address is an ordinary SRAM read.

Test Plan:
- Single burst: request 4 addrs 0x010..0x013 (first on 0x010, last on 0x013), mem model returns addr*3, m_ready=1 -> m_data=0x030,0x033,0x036,0x039; m_first on beat 0, m_last on beat 3; first beat at t+2.
- Backpressure: m_ready=0, drive 6 requests -> exactly FD=4 accepted (s_addr_ready drops after the 4th); raise m_ready -> 6 beats returned in order, none lost or duplicated.
- Simultaneous push/pop: continuous requests with m_ready=1 -> one beat per cycle sustained after the initial 2-cycle latency; FIFO count stays constant.
- Protocol error: two consecutive first without last -> proto_err=1 and stays 1; both beats still returned with first set; rst -> proto_err=0.
- Reset mid-burst: assert rst with 3 beats queued -> m_valid=0 asynchronously; after release busy=0, s_addr_ready=1, FIFO empty.
- Padding (with IFM_BANK_RSP_PAD_EN): request address 0x3FFF -> mem_ren=0 and m_data=0 returned at t+2; without the macro -> mem_ren=1 and SRAM data returned.
